// File: rtl/branch_redirect_ctrl.sv
// Branch resolution and recovery sequencer with a predictor update queue.
// Latency: redirect/flush/counter one cycle after the resolving EX cycle; queued updates visible the cycle after enqueue.
// Backpressure: ex_stall holds EX while the queue has fewer than 2 free entries or a flush is in progress.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   valid*/is_ctrl*/alucode*    EX slot qualifiers (slot 1 is older)
//   pc*/pred_taken*/pred_pc*    fetch-time PC and prediction per slot
//   taken*/target*              resolved outcome per slot
//   upd_ready / upd_*           predictor update port (head of queue)
//   redirect_valid/redirect_pc  one-cycle fetch redirect
//   flush                       kill IF..RR while recovering
//   ex_stall                    EX must hold its slots
//   mispredict_cnt              wrapping count of redirects issued
module branch_redirect_ctrl #(
  parameter int QDEPTH       = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid1,
  input  logic        valid2,
  input  logic        is_ctrl1,
  input  logic        is_ctrl2,
  input  logic [5:0]  alucode1,
  input  logic [5:0]  alucode2,
  input  logic [31:0] pc1,
  input  logic [31:0] pc2,
  input  logic        pred_taken1,
  input  logic        pred_taken2,
  input  logic [31:0] pred_pc1,
  input  logic [31:0] pred_pc2,
  input  logic        taken1,
  input  logic        taken2,
  input  logic [31:0] target1,
  input  logic [31:0] target2,
  input  logic        upd_ready,
  output logic        upd_valid,
  output logic [5:0]  upd_alucode,
  output logic        upd_taken,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        ex_stall,
  output logic [31:0] mispredict_cnt
);

  // Conditional branches occupy a contiguous ALU code range (BEQ=1 .. BGEU=6);
  // JAL=7 and JALR=8 follow and never update the predictor.
  localparam logic [5:0] ALU_BEQ  = 6'd1;
  localparam logic [5:0] ALU_BGEU = 6'd6;

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  function automatic logic is_branch(input logic [5:0] a);
    return (a >= ALU_BEQ) && (a <= ALU_BGEU);
  endfunction

  logic [0:0]        state_q, state_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [5:0]        alu_mem_q [QDEPTH];
  logic [5:0]        alu_mem_d [QDEPTH];
  logic [QDEPTH-1:0] tkn_mem_q, tkn_mem_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic [31:0]       mp_cnt_q, mp_cnt_d;

  logic              stall, live1, live2, mp1, mp2, mp_any;
  logic              enq1, enq2, deq;
  logic [31:0]       corr_pc;
  logic [CW-1:0]     nenq, ndeq;
  logic [PW-1:0]     wr2_ptr;

  // Resolution: slot 2 is on the wrong path when slot 1 is a taken control op,
  // and is also ignored entirely when slot 1 itself mispredicts.
  always_comb begin
    stall   = (count_q > CW'(QDEPTH - 2)) || (state_q == S_FLUSH);
    live1   = valid1 && is_ctrl1;
    live2   = valid2 && is_ctrl2 && !(live1 && taken1);
    mp1     = live1 && ((pred_taken1 != taken1) || (taken1 && (pred_pc1 != target1)));
    mp2     = live2 && !mp1 &&
              ((pred_taken2 != taken2) || (taken2 && (pred_pc2 != target2)));
    mp_any  = !stall && (mp1 || mp2);
    corr_pc = mp1 ? (taken1 ? target1 : pc1 + 32'd4)
                  : (taken2 ? target2 : pc2 + 32'd4);
    enq1    = !stall && live1 && is_branch(alucode1);
    enq2    = !stall && live2 && !mp1 && is_branch(alucode2);
    deq     = (count_q != '0) && upd_ready;
    nenq    = CW'(enq1) + CW'(enq2);
    ndeq    = CW'(deq);
  end

  // Update queue: slot 1 lands at the tail, slot 2 right behind it.
  always_comb begin
    alu_mem_d = alu_mem_q;
    tkn_mem_d = tkn_mem_q;
    wr2_ptr   = wr_ptr_q + PW'(enq1);
    if (enq1) begin
      alu_mem_d[wr_ptr_q] = alucode1;
      tkn_mem_d[wr_ptr_q] = taken1;
    end
    if (enq2) begin
      alu_mem_d[wr2_ptr] = alucode2;
      tkn_mem_d[wr2_ptr] = taken2;
    end
    wr_ptr_d = wr_ptr_q + PW'(nenq);
    rd_ptr_d = rd_ptr_q + PW'(ndeq);
    count_d  = count_q + nenq - ndeq;
  end

  // Recovery FSM: fcnt counts the flush cycles still to go after the current one.
  always_comb begin
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    mp_cnt_d         = mp_cnt_q;
    if (state_q == S_IDLE) begin
      if (mp_any) begin
        state_d          = S_FLUSH;
        fcnt_d           = FW'(FLUSH_CYCLES - 1);
        redirect_valid_d = 1'b1;
        redirect_pc_d    = corr_pc;
        mp_cnt_d         = mp_cnt_q + 32'd1;
      end
    end else begin
      if (fcnt_q == '0) begin
        state_d = S_IDLE;
      end else begin
        fcnt_d = fcnt_q - FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      fcnt_q           <= '0;
      count_q          <= '0;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      alu_mem_q        <= '{default: '0};
      tkn_mem_q        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mp_cnt_q         <= '0;
    end else begin
      state_q          <= state_d;
      fcnt_q           <= fcnt_d;
      count_q          <= count_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      alu_mem_q        <= alu_mem_d;
      tkn_mem_q        <= tkn_mem_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      mp_cnt_q         <= mp_cnt_d;
    end
  end

  assign upd_valid      = (count_q != '0);
  assign upd_alucode    = alu_mem_q[rd_ptr_q];
  assign upd_taken      = tkn_mem_q[rd_ptr_q];
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = (state_q == S_FLUSH);
  assign ex_stall       = stall;
  assign mispredict_cnt = mp_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed scenarios then random traffic,
// checked every cycle against a queue/counter reference model.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_branch_redirect_ctrl;

  localparam int QDEPTH       = 4;
  localparam int FLUSH_CYCLES = 2;

  localparam logic [5:0] BEQ  = 6'd1;
  localparam logic [5:0] BNE  = 6'd2;
  localparam logic [5:0] BLT  = 6'd3;
  localparam logic [5:0] BGE  = 6'd4;
  localparam logic [5:0] BLTU = 6'd5;
  localparam logic [5:0] BGEU = 6'd6;
  localparam logic [5:0] JAL  = 6'd7;
  localparam logic [5:0] JALR = 6'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid1, valid2, is_ctrl1, is_ctrl2;
  logic [5:0]  alucode1, alucode2;
  logic [31:0] pc1, pc2, pred_pc1, pred_pc2, target1, target2;
  logic        pred_taken1, pred_taken2, taken1, taken2;
  logic        upd_ready;
  logic        upd_valid, upd_taken, redirect_valid, flush, ex_stall;
  logic [5:0]  upd_alucode;
  logic [31:0] redirect_pc, mispredict_cnt;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.QDEPTH(QDEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .valid1(valid1), .valid2(valid2), .is_ctrl1(is_ctrl1), .is_ctrl2(is_ctrl2),
    .alucode1(alucode1), .alucode2(alucode2), .pc1(pc1), .pc2(pc2),
    .pred_taken1(pred_taken1), .pred_taken2(pred_taken2),
    .pred_pc1(pred_pc1), .pred_pc2(pred_pc2),
    .taken1(taken1), .taken2(taken2), .target1(target1), .target2(target2),
    .upd_ready(upd_ready), .upd_valid(upd_valid), .upd_alucode(upd_alucode),
    .upd_taken(upd_taken), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .ex_stall(ex_stall), .mispredict_cnt(mispredict_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  typedef struct {
    logic [5:0] alu;
    logic       tkn;
  } ent_t;
  ent_t        mq[$];
  int          m_flush_left;
  logic        m_rv;
  logic [31:0] m_rpc;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_br(input logic [5:0] a);
    return (a >= BEQ) && (a <= BGEU);
  endfunction

  function automatic bit wrong(input logic pt, input logic [31:0] ppc,
                               input logic t, input logic [31:0] tgt);
    return (pt != t) || (t && (ppc != tgt));
  endfunction

  task automatic model_reset();
    mq.delete();
    m_flush_left = 0;
    m_rv  = 1'b0;
    m_rpc = 32'd0;
    m_cnt = 32'd0;
  endtask

  task automatic check_outputs();
    chk("upd_valid", upd_valid, 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("upd_alucode", upd_alucode, 32'(mq[0].alu));
      chk("upd_taken", upd_taken, 32'(mq[0].tkn));
    end
    chk("ex_stall", ex_stall, 32'(((QDEPTH - mq.size()) < 2) || (m_flush_left > 0)));
    chk("flush", flush, 32'(m_flush_left > 0));
    chk("redirect_valid", redirect_valid, 32'(m_rv));
    if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    chk("mispredict_cnt", mispredict_cnt, m_cnt);
  endtask

  // What the block must do with the inputs presented this cycle.
  task automatic model_update();
    bit   stall, l1, l2, mis;
    ent_t e;
    ent_t pushes[$];
    logic [31:0] npc;
    if (rst) begin
      model_reset();
      return;
    end
    stall = ((QDEPTH - mq.size()) < 2) || (m_flush_left > 0);
    mis   = 0;
    npc   = 32'd0;
    if (!stall) begin
      l1 = valid1 && is_ctrl1;
      l2 = valid2 && is_ctrl2 && !(l1 && taken1);
      if (l1) begin
        if (is_br(alucode1)) begin e.alu = alucode1; e.tkn = taken1; pushes.push_back(e); end
        if (wrong(pred_taken1, pred_pc1, taken1, target1)) begin
          mis = 1;
          npc = taken1 ? target1 : pc1 + 32'd4;
        end
      end
      if (!mis && l2) begin
        if (is_br(alucode2)) begin e.alu = alucode2; e.tkn = taken2; pushes.push_back(e); end
        if (wrong(pred_taken2, pred_pc2, taken2, target2)) begin
          mis = 1;
          npc = taken2 ? target2 : pc2 + 32'd4;
        end
      end
    end
    if (mq.size() != 0 && upd_ready) void'(mq.pop_front());
    foreach (pushes[i]) mq.push_back(pushes[i]);
    if (m_flush_left > 0) m_flush_left--;
    m_rv = mis;
    if (mis) begin
      m_flush_left = FLUSH_CYCLES;
      m_cnt        = m_cnt + 32'd1;
      m_rpc        = npc;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_slots();
    valid1 = 0; valid2 = 0; is_ctrl1 = 0; is_ctrl2 = 0;
    alucode1 = '0; alucode2 = '0; pc1 = '0; pc2 = '0;
    pred_taken1 = 0; pred_taken2 = 0; pred_pc1 = '0; pred_pc2 = '0;
    taken1 = 0; taken2 = 0; target1 = '0; target2 = '0;
  endtask

  task automatic slot(input int k, input logic [5:0] a, input logic [31:0] pc,
                      input logic pt, input logic [31:0] ppc,
                      input logic t, input logic [31:0] tgt);
    if (k == 1) begin
      valid1 = 1; is_ctrl1 = 1; alucode1 = a; pc1 = pc;
      pred_taken1 = pt; pred_pc1 = ppc; taken1 = t; target1 = tgt;
    end else begin
      valid2 = 1; is_ctrl2 = 1; alucode2 = a; pc2 = pc;
      pred_taken2 = pt; pred_pc2 = ppc; taken2 = t; target2 = tgt;
    end
  endtask

  task automatic rand_slot(input int k);
    logic [5:0]  a;
    logic [31:0] pc, tgt, ppc;
    logic        t, pt;
    a   = 6'($urandom_range(1, 8));
    pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
    tgt = $urandom & 32'h0000_FFFC;
    t   = 1'($urandom_range(0, 1));
    pt  = ($urandom_range(0, 9) < 7) ? t : ~t;
    if (a == JALR) pt = 1'b0;
    ppc = ($urandom_range(0, 9) < 7) ? (pt ? tgt : pc + 32'd4) : ($urandom & 32'h0000_FFFC);
    slot(k, a, pc, pt, ppc, t, tgt);
    if (k == 1) begin
      valid1 = ($urandom_range(0, 3) != 0); is_ctrl1 = ($urandom_range(0, 3) != 0);
    end else begin
      valid2 = ($urandom_range(0, 3) != 0); is_ctrl2 = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    clear_slots();
    upd_ready = 0;
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    rst = 0;

    // Reset state
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_ex_stall", ex_stall, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_cnt", mispredict_cnt, 0);

    // 1: correctly predicted BEQ enqueues one entry, then pops
    slot(1, BEQ, 32'h100, 0, 32'h104, 0, 32'h200);
    step();
    clear_slots();
    chk("t1_vld", upd_valid, 1);
    chk("t1_alu", upd_alucode, 32'(BEQ));
    chk("t1_rv", redirect_valid, 0);
    upd_ready = 1;
    step();
    chk("t1_pop", upd_valid, 0);

    // 2: BNE mispredict, slot 2 is wrong-path
    slot(1, BNE, 32'h200, 0, 32'h204, 1, 32'h180);
    slot(2, BEQ, 32'h204, 1, 32'h999, 0, 32'h300);
    step();
    clear_slots();
    chk("t2_rv", redirect_valid, 1);
    chk("t2_rpc", redirect_pc, 32'h180);
    chk("t2_flush1", flush, 1);
    chk("t2_cnt", mispredict_cnt, 1);
    step();
    chk("t2_rv_off", redirect_valid, 0);
    chk("t2_flush2", flush, 1);
    step();
    chk("t2_flush_end", flush, 0);

    // 3: slot 2 mispredicts not-taken -> fall through to pc+4
    upd_ready = 0;
    slot(1, BLT, 32'h30, 0, 32'h34, 0, 32'h10);
    slot(2, BGE, 32'h3C, 1, 32'h40, 0, 32'h40);
    step();
    clear_slots();
    chk("t3_rv", redirect_valid, 1);
    chk("t3_rpc", redirect_pc, 32'h40);
    chk("t3_head", upd_alucode, 32'(BLT));
    step(); step();
    upd_ready = 1;
    repeat (3) step();
    chk("t3_drained", upd_valid, 0);

    // 4: backpressure with two enqueues per cycle
    upd_ready = 0;
    repeat (3) begin
      slot(1, BLTU, 32'h400, 0, 32'h404, 0, 32'h800);
      slot(2, BGEU, 32'h404, 0, 32'h408, 0, 32'h900);
      step();
    end
    clear_slots();
    chk("t4_stall", ex_stall, 1);
    upd_ready = 1;
    repeat (5) step();
    chk("t4_empty", upd_valid, 0);

    // 5: correctly predicted JAL shadows slot 2
    slot(1, JAL, 32'h500, 1, 32'h600, 1, 32'h600);
    slot(2, BEQ, 32'h504, 0, 32'h508, 0, 32'h700);
    step();
    clear_slots();
    chk("t5_vld", upd_valid, 0);
    chk("t5_rv", redirect_valid, 0);

    // 6: reset during flush with three queued entries
    upd_ready = 0;
    slot(1, BEQ, 32'h600, 0, 32'h604, 0, 32'h10);
    slot(2, BNE, 32'h604, 0, 32'h608, 0, 32'h20);
    step();
    slot(1, BNE, 32'h700, 0, 32'h704, 1, 32'h740);
    valid2 = 0;
    step();
    clear_slots();
    chk("t6_flush", flush, 1);
    rst = 1;
    step();
    rst = 0;
    chk("t6_flush0", flush, 0);
    chk("t6_vld0", upd_valid, 0);
    chk("t6_stall0", ex_stall, 0);
    chk("t6_cnt0", mispredict_cnt, 0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      rand_slot(1);
      rand_slot(2);
      upd_ready = ($urandom_range(0, 9) < 6);
      rst       = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 0;
    clear_slots();
    upd_ready = 1;
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
